mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of SRAM strobe cycles per access before data is sampled (legal 1..15).
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 MIO_EN  input  1  CPU memory request; held high with ADDR/R_W/Data_In stable until R is seen.
REQ-005 R_W  input  1  1 = write, 0 = read.
REQ-006 ADDR  input  16  word address (from MAR).
REQ-007 Data_In  input  16  write data (from MDR).
REQ-008 Data_Out  output  16  read data to CPU; registered.
REQ-009 R  output  1  ready; one-cycle pulse completing a request.
REQ-010 SRAM_ADDR / SRAM_Dout  output  16 / 16  SRAM address / write data; registered.
REQ-011 SRAM_Din  input  16  SRAM read data.
REQ-012 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes; registered.
REQ-013 Key_Valid  input  1  one-cycle pulse: new keyboard byte on Key_Data.
REQ-014 Key_Data  input  8  keyboard byte.
REQ-015 Disp_Ready  input  1  display accepts a byte.
REQ-016 Disp_Valid / Disp_Data  output  1 / 8  one-cycle display write strobe / byte.

Function
REQ-017 FSM states SHALL be IDLE, SRAM_ACC, DEV_ACC, DONE, RELEASE.
REQ-018 IDLE: MIO_EN=1 with ADDR < xFE00 -> SRAM_ACC; MIO_EN=1 with ADDR >= xFE00 -> DEV_ACC; else stay.
REQ-019 SRAM_ACC SHALL last exactly WAIT_STATES+1 cycles (internal counter); SRAM_ADDR=ADDR, SRAM_CE_N=0 throughout.
REQ-020 Read access: SRAM_OE_N=0, SRAM_WE_N=1 throughout; Data_Out <= SRAM_Din at end of final SRAM_ACC cycle.
REQ-021 Write access: SRAM_OE_N=1, SRAM_Dout=Data_In; SRAM_WE_N=0 for first WAIT_STATES cycles, 1 on final cycle (data/address hold).
REQ-022 DEV_ACC SHALL last 1 cycle, performing the device action of REQ-026..REQ-030.
REQ-023 DONE: R=1 for exactly one cycle, all SRAM strobes high; then -> RELEASE.
REQ-024 RELEASE: stay while MIO_EN=1; MIO_EN=0 -> IDLE (no back-to-back request without one low cycle).
REQ-025 Latency: R high in cycle WAIT_STATES+2 (SRAM) or 2 (device) after the edge sampling MIO_EN=1 in IDLE.
REQ-026 xFE00 KBSR read: Data_Out={kbd_full,15'b0}; writes ignored.
REQ-027 xFE02 KBDR read: Data_Out={8'h00,kbd_data}; clears kbd_full; writes ignored.
REQ-028 xFE04 DSR read: Data_Out={Disp_Ready,15'b0}; writes ignored.
REQ-029 xFE06 DDR write: Disp_Data<=Data_In[7:0], Disp_Valid=1 next cycle for one cycle; read returns x0000.
REQ-030 Other xFE00-xFFFF: read x0000, write ignored, R still issued.
REQ-031 Key_Valid with kbd_full=0: kbd_data<=Key_Data, kbd_full<=1; with kbd_full=1 and no concurrent KBDR read: byte dropped.
REQ-032 Key_Valid in same cycle as KBDR read clear: new byte loaded, kbd_full stays 1 (set wins).
REQ-033 Data_Out SHALL hold its value until the next read completes; writes do not change it.
REQ-034 Request fields SHALL be sampled every access cycle, not latched; CPU stability is a protocol obligation.

Reset
REQ-035 Reset=1 SHALL immediately force: state IDLE, counter 0, R=0, Data_Out=x0000, SRAM_ADDR=x0000, SRAM_Dout=x0000, all SRAM strobes 1, Disp_Valid=0, Disp_Data=x00, kbd_full=0, kbd_data=x00.
REQ-036 Reset mid-access SHALL abort the transaction with strobes deasserted asynchronously and no R pulse.

Verification
REQ-037 WAIT_STATES=2, read ADDR=x3000, SRAM_Din=xBEEF -> CE_N/OE_N low 3 cycles, R pulse 4 cycles after request, Data_Out=xBEEF.
REQ-038 Write ADDR=x3001, Data_In=x1234 -> WE_N low 2 cycles then high 1, SRAM_Dout=x1234, R one cycle, Data_Out unchanged.
REQ-039 Key_Valid with x41; read xFE00 -> x8000; read xFE02 -> x0041; read xFE00 -> x0000.
REQ-040 Disp_Ready=1: read xFE04 -> x8000; write xFE06 x0158 -> Disp_Data=x58, Disp_Valid one-cycle pulse, R after 2 cycles.
REQ-041 MIO_EN held high 5 cycles after R -> no second R; drop 1 cycle, reassert -> new access begins.
REQ-042 Reset asserted in 2nd SRAM_ACC cycle of a write -> WE_N/CE_N high immediately, no R, IDLE after release.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: CPU memory/MMIO responder with a wait-stated SRAM port, keyboard and display registers.
// Ports:
//   Clk, Reset          clock and asynchronous active-high reset
//   MIO_EN, R_W         request (held until R) and direction (1 = write)
//   ADDR, Data_In       word address and write data
//   Data_Out, R         registered read data and one-cycle ready pulse
//   SRAM_*              registered SRAM address/data/strobes (strobes active-low), SRAM_Din read data
//   Key_Valid, Key_Data keyboard byte strobe and byte
//   Disp_Ready          display can accept a byte
//   Disp_Valid, Disp_Data display write strobe and byte
module mem_responder #(
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_In,
    output logic [15:0] Data_Out,
    output logic        R,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_Dout,
    input  logic [15:0] SRAM_Din,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    input  logic        Key_Valid,
    input  logic [7:0]  Key_Data,
    input  logic        Disp_Ready,
    output logic        Disp_Valid,
    output logic [7:0]  Disp_Data
);
    typedef enum logic [2:0] {IDLE, SRAM_ACC, DEV_ACC, DONE, RELEASE} state_t;
    localparam logic [3:0] LAST = 4'(WAIT_STATES);
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        last, acc_n, dev_rd_en, kbdr_rd, ddr_wr, kbd_full;
    logic [7:0]  kbd_data;
    logic [15:0] dev_rd;
    assign last      = cnt == LAST;
    assign R         = state == DONE;
    assign acc_n     = state_n == SRAM_ACC;
    assign dev_rd_en = state == DEV_ACC && !R_W;
    assign kbdr_rd   = dev_rd_en && ADDR == 16'hFE02;
    assign ddr_wr    = state == DEV_ACC && R_W && ADDR == 16'hFE06;
    assign dev_rd    = ADDR == 16'hFE00 ? {kbd_full, 15'b0} :
                       ADDR == 16'hFE02 ? {8'h00, kbd_data} :
                       ADDR == 16'hFE04 ? {Disp_Ready, 15'b0} : 16'h0000;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            IDLE:     if (MIO_EN) state_n = ADDR < 16'hFE00 ? SRAM_ACC : DEV_ACC;
            SRAM_ACC: begin
                cnt_n   = last ? 4'd0 : cnt + 4'd1;
                state_n = last ? DONE : SRAM_ACC;
            end
            DEV_ACC:  state_n = DONE;
            DONE:     state_n = RELEASE;
            RELEASE:  if (!MIO_EN) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // Strobes are registered from the next state/count so they are valid for the whole access cycle;
    // WE_N rises for the final cycle to hold address/data past the write edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Data_Out   <= '0;
            SRAM_ADDR  <= '0;
            SRAM_Dout  <= '0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            Disp_Valid <= 1'b0;
            Disp_Data  <= '0;
            kbd_full   <= 1'b0;
            kbd_data   <= '0;
        end else begin
            SRAM_CE_N  <= !acc_n;
            SRAM_OE_N  <= !(acc_n && !R_W);
            SRAM_WE_N  <= !(acc_n && R_W && cnt_n < LAST);
            if (acc_n) SRAM_ADDR <= ADDR;
            if (acc_n && R_W) SRAM_Dout <= Data_In;
            if (state == SRAM_ACC && last && !R_W) Data_Out <= SRAM_Din;
            if (dev_rd_en) Data_Out <= dev_rd;
            Disp_Valid <= ddr_wr;
            if (ddr_wr) Disp_Data <= Data_In[7:0];
            // A new key arriving on the same edge as a KBDR read refills the buffer (set wins).
            if (Key_Valid && (!kbd_full || kbdr_rd)) begin
                kbd_data <= Key_Data;
                kbd_full <= 1'b1;
            end else if (kbdr_rd) begin
                kbd_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder with an SRAM and keyboard/display model.
module tb_mem_responder;
    localparam int WS = 2;
    logic        Clk = 0, Reset = 0, MIO_EN = 0, R_W = 0;
    logic [15:0] ADDR = 0, Data_In = 0;
    logic [15:0] Data_Out, SRAM_ADDR, SRAM_Dout, SRAM_Din;
    logic        R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, Disp_Valid;
    logic        Key_Valid = 0, Disp_Ready = 0;
    logic [7:0]  Key_Data = 0, Disp_Data;

    mem_responder #(.WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .ADDR(ADDR), .Data_In(Data_In),
        .Data_Out(Data_Out), .R(R), .SRAM_ADDR(SRAM_ADDR), .SRAM_Dout(SRAM_Dout), .SRAM_Din(SRAM_Din),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .Key_Valid(Key_Valid), .Key_Data(Key_Data), .Disp_Ready(Disp_Ready),
        .Disp_Valid(Disp_Valid), .Disp_Data(Disp_Data));

    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc++;

    logic [15:0] sram [0:65535];
    assign SRAM_Din = sram[SRAM_ADDR];
    always @(negedge Clk) if (!SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR] = SRAM_Dout;

    typedef struct {
        logic [15:0] dout, addr, wdata;
        int          lat, ce, oe, we, disp, issue;
        logic [7:0]  dbyte;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, done_cnt = 0;

    logic [15:0] ref_dout;
    logic        kfull;
    logic [7:0]  kdata;
    logic [15:0] ref_w [logic [15:0]];

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return ref_w.exists(a) ? ref_w[a] : (a ^ 16'hA5C3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    int n_ce, n_oe, n_we, n_disp;
    logic [15:0] a_seen, d_seen;
    logic [7:0]  disp_seen;
    exp_t e;
    always @(negedge Clk) begin
        if (Reset) begin
            n_ce = 0; n_oe = 0; n_we = 0; n_disp = 0;
        end else begin
            if (!SRAM_CE_N) begin n_ce++; a_seen = SRAM_ADDR; end
            if (!SRAM_OE_N) n_oe++;
            if (!SRAM_WE_N) begin n_we++; d_seen = SRAM_Dout; end
            if (Disp_Valid) begin n_disp++; disp_seen = Disp_Data; end
            if (q.size() == 0) check("spurious_R", R, 0);
            else if (R) begin
                e = q.pop_front();
                check("data_out", Data_Out, e.dout);
                check("latency", cyc - e.issue, e.lat);
                check("ce_cycles", n_ce, e.ce);
                check("oe_cycles", n_oe, e.oe);
                check("we_cycles", n_we, e.we);
                check("disp_pulses", n_disp, e.disp);
                if (e.ce > 0) check("sram_addr", a_seen, e.addr);
                if (e.we > 0) check("sram_dout", d_seen, e.wdata);
                if (e.disp > 0) check("disp_data", disp_seen, e.dbyte);
                n_ce = 0; n_oe = 0; n_we = 0; n_disp = 0;
                done_cnt++;
            end
        end
    end

    // Called at a negedge; returns at a negedge with MIO_EN low for exactly one cycle behind it.
    task automatic do_req(input logic rw, input logic [15:0] a, input logic [15:0] d,
                          input logic key_mid, input logic [7:0] kb, input int hold,
                          input logic key_gap, input logic [7:0] gb);
        exp_t x;
        int n, d0;
        logic clr;
        MIO_EN = 1; R_W = rw; ADDR = a; Data_In = d;
        x.issue = cyc; x.addr = a; x.wdata = d; x.disp = 0; x.dbyte = 0; clr = 0;
        if (a < 16'hFE00) begin
            x.lat = WS + 2; x.ce = WS + 1; x.oe = rw ? 0 : WS + 1; x.we = rw ? WS : 0;
            if (rw) ref_w[a] = d;
            else ref_dout = mem_val(a);
        end else begin
            x.lat = 2; x.ce = 0; x.oe = 0; x.we = 0;
            if (rw) begin
                if (a == 16'hFE06) begin x.disp = 1; x.dbyte = d[7:0]; end
            end else begin
                ref_dout = a == 16'hFE00 ? {kfull, 15'b0} :
                           a == 16'hFE02 ? {8'h00, kdata} :
                           a == 16'hFE04 ? {Disp_Ready, 15'b0} : 16'h0000;
                clr = a == 16'hFE02;
            end
            if (clr) kfull = 0;
        end
        if (key_mid && !kfull) begin kfull = 1; kdata = kb; end
        x.dout = ref_dout;
        q.push_back(x);
        d0 = done_cnt;
        if (key_mid) begin
            @(negedge Clk); Key_Valid = 1; Key_Data = kb;
            @(negedge Clk); Key_Valid = 0;
        end
        #1;
        n = 0;
        while (done_cnt == d0 && n < 40) begin @(negedge Clk); #1; n++; end
        if (done_cnt == d0) begin
            check("timeout", done_cnt, d0 + 1);
            if (q.size() > 0) q.delete(0);
        end
        repeat (hold) @(negedge Clk);
        MIO_EN = 0;
        if (key_gap) begin
            Key_Valid = 1; Key_Data = gb;
            if (!kfull) begin kfull = 1; kdata = gb; end
        end
        @(negedge Clk);
        Key_Valid = 0;
    endtask

    initial begin
        logic rw, km, kg;
        logic [15:0] a, d;
        int cat;
        for (int i = 0; i < 65536; i++) sram[i] = 16'(i) ^ 16'hA5C3;
        sram[16'h3000] = 16'hBEEF; ref_w[16'h3000] = 16'hBEEF;
        ref_dout = 0; kfull = 0; kdata = 0;
        #1 Reset = 1;
        #2;
        check("rst_data_out", Data_Out, 16'h0000);
        check("rst_R", R, 0);
        check("rst_sram_addr", SRAM_ADDR, 16'h0000);
        check("rst_sram_dout", SRAM_Dout, 16'h0000);
        check("rst_ce_n", SRAM_CE_N, 1);
        check("rst_oe_n", SRAM_OE_N, 1);
        check("rst_we_n", SRAM_WE_N, 1);
        check("rst_disp_valid", Disp_Valid, 0);
        check("rst_disp_data", Disp_Data, 8'h00);
        repeat (3) @(negedge Clk);
        Reset = 0;
        @(negedge Clk);
        do_req(0, 16'h3000, 0, 0, 0, 1, 0, 0);
        do_req(1, 16'h3001, 16'h1234, 0, 0, 2, 0, 0);
        do_req(0, 16'h3001, 0, 0, 0, 1, 1, 8'h41);
        do_req(0, 16'hFE00, 0, 0, 0, 1, 0, 0);
        do_req(0, 16'hFE02, 0, 0, 0, 3, 0, 0);
        do_req(0, 16'hFE00, 0, 0, 0, 1, 0, 0);
        Disp_Ready = 1;
        do_req(0, 16'hFE04, 0, 0, 0, 1, 0, 0);
        do_req(1, 16'hFE06, 16'h0158, 0, 0, 5, 1, 8'h11);
        do_req(0, 16'hFE02, 0, 1, 8'h22, 1, 0, 0);
        do_req(0, 16'hFE00, 0, 0, 0, 1, 0, 0);
        do_req(0, 16'hFE02, 0, 0, 0, 1, 1, 8'h44);
        do_req(0, 16'hFE00, 0, 0, 0, 1, 1, 8'h55);
        do_req(0, 16'hFE02, 0, 0, 0, 1, 0, 0);
        do_req(0, 16'hFDFF, 0, 0, 0, 1, 0, 0);
        do_req(1, 16'hFDFF, 16'hCAFE, 0, 0, 1, 0, 0);
        do_req(0, 16'h0000, 0, 0, 0, 1, 0, 0);
        do_req(0, 16'hFDFF, 0, 0, 0, 1, 0, 0);
        do_req(1, 16'hFE00, 16'hFFFF, 0, 0, 1, 0, 0);
        do_req(0, 16'hFFFF, 0, 0, 0, 1, 0, 0);
        do_req(0, 16'hFE01, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 150; i++) begin
            rw = 1'($urandom_range(0, 1));
            cat = $urandom_range(0, 5);
            a = cat < 2 ? 16'h3000 + 16'($urandom_range(0, 15)) :
                cat == 2 ? 16'($urandom_range(0, 16'hFDFF)) :
                cat < 5 ? 16'hFE00 + 16'(2 * $urandom_range(0, 3)) :
                16'($urandom_range(16'hFE00, 16'hFFFF));
            d = 16'($urandom);
            km = $urandom_range(0, 3) == 0;
            kg = $urandom_range(0, 2) == 0;
            Disp_Ready = 1'($urandom_range(0, 1));
            do_req(rw, a, d, km, 8'($urandom), $urandom_range(1, 5), kg, 8'($urandom));
        end
        MIO_EN = 1; R_W = 1; ADDR = 16'h3005; Data_In = 16'h5A5A;
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1;
        #1;
        check("abort_ce_n", SRAM_CE_N, 1);
        check("abort_we_n", SRAM_WE_N, 1);
        check("abort_R", R, 0);
        check("abort_data_out", Data_Out, 16'h0000);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 0; MIO_EN = 0;
        ref_w[16'h3005] = 16'h5A5A; ref_dout = 0; kfull = 0; kdata = 0;
        repeat (4) @(negedge Clk);
        do_req(0, 16'hFE00, 0, 0, 0, 1, 0, 0);
        do_req(0, 16'h3005, 0, 0, 0, 1, 0, 0);
        do_req(1, 16'h3006, 16'h0F0F, 0, 0, 1, 0, 0);
        do_req(0, 16'h3006, 0, 0, 0, 1, 0, 0);
        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
